// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// Carries register-address hazard inputs and the stall/flush/forwarding decisions.
interface pipeline_ctrl_if;
  logic [4:0]  id_Rs, id_Rt;
  logic        id_UsesRs, id_UsesRt, id_Jump;
  logic [4:0]  ex_Rs, ex_Rt;
  logic        ex_MemRead, ex_MulDiv;
  logic [4:0]  ex_RegWriteAddr;
  logic        ex_activeBranch;
  logic        ex_mem_RegWrite, mem_wb_RegWrite;
  logic [4:0]  ex_mem_RegWriteAddr, mem_wb_RegWriteAddr;

  logic        pc_hold;
  logic [1:0]  if_id_regOption, id_ex_regOption, ex_mem_regOption;
  logic [1:0]  forwardA, forwardB;
  logic        muldiv_start;
  logic [31:0] stall_cycles, flush_count;

  modport master (
    output id_Rs, id_Rt, id_UsesRs, id_UsesRt, id_Jump,
           ex_Rs, ex_Rt, ex_MemRead, ex_MulDiv, ex_RegWriteAddr, ex_activeBranch,
           ex_mem_RegWrite, mem_wb_RegWrite, ex_mem_RegWriteAddr, mem_wb_RegWriteAddr,
    input  pc_hold, if_id_regOption, id_ex_regOption, ex_mem_regOption,
           forwardA, forwardB, muldiv_start, stall_cycles, flush_count
  );

  modport slave (
    input  id_Rs, id_Rt, id_UsesRs, id_UsesRt, id_Jump,
           ex_Rs, ex_Rt, ex_MemRead, ex_MulDiv, ex_RegWriteAddr, ex_activeBranch,
           ex_mem_RegWrite, mem_wb_RegWrite, ex_mem_RegWriteAddr, mem_wb_RegWriteAddr,
    output pc_hold, if_id_regOption, id_ex_regOption, ex_mem_regOption,
           forwardA, forwardB, muldiv_start, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall, branch/jump flush,
// multi-cycle mul/div hold sequencing and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MULDIV_LAT = 32  // legal 2..255
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1, MD_DONE = 2'd2} state_t;

  localparam logic [1:0] OPT_UPDATE = 2'b00;
  localparam logic [1:0] OPT_BUBBLE = 2'b01;
  localparam logic [1:0] OPT_HOLD   = 2'b10;
  localparam logic [7:0] CNT_LOAD   = 8'(MULDIV_LAT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] stallCycles, flushCount;

  logic        loadUse, branchFlush;
  logic        pcHold, mdStart;
  logic [1:0]  ifIdOpt, idExOpt, exMemOpt;
  logic [1:0]  fwdA, fwdB;

  function automatic logic [1:0] fwdSel(
    input logic       exmWrite, input logic [4:0] exmAddr,
    input logic       mwWrite,  input logic [4:0] mwAddr,
    input logic [4:0] src
  );
    if (exmWrite && exmAddr != 5'd0 && exmAddr == src) return 2'b10;
    if (mwWrite  && mwAddr  != 5'd0 && mwAddr  == src) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (!reset) begin
      fwdA = fwdSel(bus.ex_mem_RegWrite, bus.ex_mem_RegWriteAddr,
                    bus.mem_wb_RegWrite, bus.mem_wb_RegWriteAddr, bus.ex_Rs);
      fwdB = fwdSel(bus.ex_mem_RegWrite, bus.ex_mem_RegWriteAddr,
                    bus.mem_wb_RegWrite, bus.mem_wb_RegWriteAddr, bus.ex_Rt);
    end
  end

  assign loadUse = bus.ex_MemRead && (bus.ex_RegWriteAddr != 5'd0) &&
                   ((bus.id_UsesRs && bus.id_Rs == bus.ex_RegWriteAddr) ||
                    (bus.id_UsesRt && bus.id_Rt == bus.ex_RegWriteAddr));

  // Decisions depend on this cycle's EX/ID contents, so they are decoded
  // combinationally from the registered state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pcHold      = 1'b0;
    ifIdOpt     = OPT_UPDATE;
    idExOpt     = OPT_UPDATE;
    exMemOpt    = OPT_UPDATE;
    mdStart     = 1'b0;
    branchFlush = 1'b0;
    if (reset) begin
      pcHold   = 1'b1;
      ifIdOpt  = OPT_BUBBLE;
      idExOpt  = OPT_BUBBLE;
      exMemOpt = OPT_BUBBLE;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.ex_activeBranch) begin
            ifIdOpt     = OPT_BUBBLE;
            idExOpt     = OPT_BUBBLE;
            branchFlush = 1'b1;
          end else if (bus.ex_MulDiv) begin
            mdStart  = 1'b1;
            pcHold   = 1'b1;
            ifIdOpt  = OPT_HOLD;
            idExOpt  = OPT_HOLD;
            exMemOpt = OPT_BUBBLE;
          end else if (loadUse) begin
            pcHold  = 1'b1;
            ifIdOpt = OPT_HOLD;
            idExOpt = OPT_BUBBLE;
          end else if (bus.id_Jump) begin
            ifIdOpt = OPT_BUBBLE;
          end
        end
        MD_WAIT: begin
          pcHold   = 1'b1;
          ifIdOpt  = OPT_HOLD;
          idExOpt  = OPT_HOLD;
          exMemOpt = OPT_BUBBLE;
        end
        default: ;  // MD_DONE releases the pipeline for one cycle so the op is not re-issued
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state       <= RUN;
      cnt         <= 8'd0;
      stallCycles <= 32'd0;
      flushCount  <= 32'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (!bus.ex_activeBranch && bus.ex_MulDiv) begin
            state <= MD_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        MD_WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= MD_DONE;
        end
        default: state <= RUN;
      endcase
      if (pcHold && stallCycles != 32'hFFFF_FFFF) stallCycles <= stallCycles + 32'd1;
      if (branchFlush && flushCount != 32'hFFFF_FFFF) flushCount <= flushCount + 32'd1;
    end
  end

  assign bus.pc_hold          = pcHold;
  assign bus.if_id_regOption  = ifIdOpt;
  assign bus.id_ex_regOption  = idExOpt;
  assign bus.ex_mem_regOption = exMemOpt;
  assign bus.forwardA         = fwdA;
  assign bus.forwardB         = fwdB;
  assign bus.muldiv_start     = mdStart;
  assign bus.stall_cycles     = stallCycles;
  assign bus.flush_count      = flushCount;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed multi-cycle sequences,
// then random stimulus against a cycle-count reference model.
module tb_pipeline_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();
  pipeline_ctrl #(.MULDIV_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [4:0] idRs, idRt;
    logic       idUsesRs, idUsesRt, idJump;
    logic [4:0] exRs, exRt;
    logic       exMemRead, exMulDiv;
    logic [4:0] exWa;
    logic       exBranch;
    logic       exmW;
    logic [4:0] exmA;
    logic       mwW;
    logic [4:0] mwA;
  } in_t;

  typedef struct packed {
    logic       hold;
    logic [1:0] ifId, idEx, exMem, fa, fb;
    logic       start;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: a count of remaining held cycles plus a one-cycle release flag.
  int          mdLeft;
  bit          mdDone;
  logic [31:0] mStall, mFlush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x = '0;
    return x;
  endfunction

  function automatic exp_t mk(logic h, logic [1:0] a, logic [1:0] b, logic [1:0] c,
                              logic [1:0] fa, logic [1:0] fb, logic s);
    exp_t e;
    e.hold = h; e.ifId = a; e.idEx = b; e.exMem = c; e.fa = fa; e.fb = fb; e.start = s;
    return e;
  endfunction

  function automatic logic [1:0] refFwd(in_t x, logic [4:0] src);
    if (x.exmW && x.exmA != 0 && x.exmA == src) return 2'b10;
    if (x.mwW && x.mwA != 0 && x.mwA == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit refLoadUse(in_t x);
    return x.exMemRead && x.exWa != 0 &&
           ((x.idUsesRs && x.idRs == x.exWa) || (x.idUsesRt && x.idRt == x.exWa));
  endfunction

  function automatic exp_t predict(in_t x, bit r);
    if (r) return mk(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    if (mdLeft > 0) return mk(1, 2'b10, 2'b10, 2'b01, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
    if (mdDone) return mk(0, 0, 0, 0, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
    if (x.exBranch) return mk(0, 2'b01, 2'b01, 0, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
    if (x.exMulDiv) return mk(1, 2'b10, 2'b10, 2'b01, refFwd(x, x.exRs), refFwd(x, x.exRt), 1);
    if (refLoadUse(x)) return mk(1, 2'b10, 2'b01, 0, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
    if (x.idJump) return mk(0, 2'b01, 0, 0, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
    return mk(0, 0, 0, 0, refFwd(x, x.exRs), refFwd(x, x.exRt), 0);
  endfunction

  task automatic advance(input in_t x, input bit r);
    exp_t e = predict(x, r);
    bit flushing = !r && mdLeft == 0 && !mdDone && x.exBranch;
    if (r) begin
      mdLeft = 0; mdDone = 0; mStall = 0; mFlush = 0;
      return;
    end
    if (e.hold && mStall != 32'hFFFF_FFFF) mStall++;
    if (flushing && mFlush != 32'hFFFF_FFFF) mFlush++;
    if (mdLeft > 0) begin
      mdLeft--;
      if (mdLeft == 0) mdDone = 1;
    end else if (mdDone) mdDone = 0;
    else if (!x.exBranch && x.exMulDiv) mdLeft = LAT - 1;
  endtask

  task automatic drive(input in_t x, input bit r);
    reset = r;
    bus.id_Rs = x.idRs; bus.id_Rt = x.idRt;
    bus.id_UsesRs = x.idUsesRs; bus.id_UsesRt = x.idUsesRt; bus.id_Jump = x.idJump;
    bus.ex_Rs = x.exRs; bus.ex_Rt = x.exRt;
    bus.ex_MemRead = x.exMemRead; bus.ex_MulDiv = x.exMulDiv;
    bus.ex_RegWriteAddr = x.exWa; bus.ex_activeBranch = x.exBranch;
    bus.ex_mem_RegWrite = x.exmW; bus.ex_mem_RegWriteAddr = x.exmA;
    bus.mem_wb_RegWrite = x.mwW; bus.mem_wb_RegWriteAddr = x.mwA;
  endtask

  task automatic checkOuts(input exp_t e, input string tag);
    check({tag, ".pc_hold"}, 32'(bus.pc_hold), 32'(e.hold));
    check({tag, ".if_id"}, 32'(bus.if_id_regOption), 32'(e.ifId));
    check({tag, ".id_ex"}, 32'(bus.id_ex_regOption), 32'(e.idEx));
    check({tag, ".ex_mem"}, 32'(bus.ex_mem_regOption), 32'(e.exMem));
    check({tag, ".forwardA"}, 32'(bus.forwardA), 32'(e.fa));
    check({tag, ".forwardB"}, 32'(bus.forwardB), 32'(e.fb));
    check({tag, ".muldiv_start"}, 32'(bus.muldiv_start), 32'(e.start));
    check({tag, ".stall_cycles"}, bus.stall_cycles, mStall);
    check({tag, ".flush_count"}, bus.flush_count, mFlush);
  endtask

  // One clock: inputs applied after the edge, outputs compared at the falling edge.
  task automatic step(input in_t x, input bit r, input string tag,
                      output logic obsHold, output logic obsStart);
    drive(x, r);
    @(negedge clk);
    checkOuts(predict(x, r), tag);
    obsHold = bus.pc_hold;
    obsStart = bus.muldiv_start;
    advance(x, r);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t x;
    vec_t v;
    logic h, s;
    int holds, starts;
    logic [31:0] stallBefore, flushBefore;

    // Vector table (each applied from RUN with an otherwise idle pipeline)
    v.name = "idle"; v.in = idle(); v.exp = mk(0, 0, 0, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "fwd_exmem_prio"; v.in = idle();
    v.in.exRs = 5; v.in.exmW = 1; v.in.exmA = 5; v.in.mwW = 1; v.in.mwA = 5;
    v.exp = mk(0, 0, 0, 0, 2'b10, 0, 0); tbl.push_back(v);
    v.name = "fwd_exmem_r0"; v.in.exmA = 0;
    v.exp = mk(0, 0, 0, 0, 2'b01, 0, 0); tbl.push_back(v);
    v.name = "fwd_none"; v.in.mwW = 0;
    v.exp = mk(0, 0, 0, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "fwd_split"; v.in = idle();
    v.in.exRt = 7; v.in.exmW = 1; v.in.exmA = 7; v.in.exRs = 3; v.in.mwW = 1; v.in.mwA = 3;
    v.exp = mk(0, 0, 0, 0, 2'b01, 2'b10, 0); tbl.push_back(v);
    v.name = "fwd_we_gate"; v.in = idle();
    v.in.exRt = 7; v.in.exmA = 7; v.in.mwW = 1; v.in.mwA = 7;
    v.exp = mk(0, 0, 0, 0, 0, 2'b01, 0); tbl.push_back(v);
    v.name = "jump"; v.in = idle(); v.in.idJump = 1;
    v.exp = mk(0, 2'b01, 0, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "lu_rs"; v.in = idle();
    v.in.exMemRead = 1; v.in.exWa = 9; v.in.idRs = 9; v.in.idUsesRs = 1;
    v.exp = mk(1, 2'b10, 2'b01, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "lu_rs_unused"; v.in.idUsesRs = 0;
    v.exp = mk(0, 0, 0, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "lu_r0"; v.in = idle(); v.in.exMemRead = 1; v.in.idUsesRs = 1;
    v.exp = mk(0, 0, 0, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "lu_over_jump"; v.in = idle();
    v.in.exMemRead = 1; v.in.exWa = 12; v.in.idRt = 12; v.in.idUsesRt = 1; v.in.idJump = 1;
    v.exp = mk(1, 2'b10, 2'b01, 0, 0, 0, 0); tbl.push_back(v);
    v.name = "branch_over_jump"; v.in = idle(); v.in.exBranch = 1; v.in.idJump = 1;
    v.exp = mk(0, 2'b01, 2'b01, 0, 0, 0, 0); tbl.push_back(v);

    // Reset: first edges settle the state, then the model starts from its reset state
    drive(idle(), 1);
    repeat (2) @(posedge clk);
    #1;
    mdLeft = 0; mdDone = 0; mStall = 0; mFlush = 0;
    step(idle(), 1, "reset", h, s);

    foreach (tbl[i]) begin
      drive(tbl[i].in, 0);
      @(negedge clk);
      checkOuts(tbl[i].exp, tbl[i].name);
      advance(tbl[i].in, 0);
      @(posedge clk); #1;
    end

    // Load-use through Rt: one stalled cycle
    stallBefore = mStall;
    x = idle(); x.exMemRead = 1; x.exWa = 8; x.idRt = 8; x.idUsesRt = 1;
    step(x, 0, "lu_rt", h, s);
    step(idle(), 0, "lu_rt_after", h, s);
    check("lu_rt_stall_delta", bus.stall_cycles - stallBefore, 32'd1);

    // Branch and load-use together: flush wins, no stall
    stallBefore = bus.stall_cycles; flushBefore = bus.flush_count;
    x.exBranch = 1;
    step(x, 0, "branch_lu", h, s);
    step(idle(), 0, "branch_lu_after", h, s);
    check("branch_lu_flush_delta", bus.flush_count - flushBefore, 32'd1);
    check("branch_lu_stall_delta", bus.stall_cycles - stallBefore, 32'd0);

    // Mul/div with ex_MulDiv held through the release cycle
    stallBefore = bus.stall_cycles; holds = 0; starts = 0;
    x = idle(); x.exMulDiv = 1;
    for (int c = 0; c < LAT + 1; c++) begin
      step(x, 0, $sformatf("md_c%0d", c), h, s);
      holds += int'(h); starts += int'(s);
    end
    step(idle(), 0, "md_run", h, s);
    check("md_start_pulses", 32'(starts), 32'd1);
    check("md_hold_cycles", 32'(holds), 32'(LAT));
    check("md_stall_delta", bus.stall_cycles - stallBefore, 32'(LAT));

    // Reset in the second MD_WAIT cycle aborts the sequence
    step(x, 0, "mdr_detect", h, s);
    step(x, 0, "mdr_wait1", h, s);
    step(x, 1, "mdr_reset", h, s);
    step(idle(), 0, "mdr_run", h, s);
    check("mdr_stall_zero", bus.stall_cycles, 32'd0);
    check("mdr_flush_zero", bus.flush_count, 32'd0);
    step(x, 0, "mdr_restart", h, s);
    for (int c = 0; c < LAT; c++) step(idle(), 0, "mdr_drain", h, s);

    // Saturation of the stall counter
    dut.stallCycles = 32'hFFFF_FFFF;
    mStall = 32'hFFFF_FFFF;
    x = idle(); x.exMemRead = 1; x.exWa = 4; x.idRs = 4; x.idUsesRs = 1;
    step(x, 0, "sat_stall", h, s);
    step(x, 0, "sat_stall2", h, s);
    check("sat_value", bus.stall_cycles, 32'hFFFF_FFFF);
    step(idle(), 1, "sat_reset", h, s);

    // Random stimulus against the reference model
    for (int n = 0; n < 400; n++) begin
      x.idRs = 5'($urandom_range(0, 3)); x.idRt = 5'($urandom_range(0, 3));
      x.idUsesRs = 1'($urandom); x.idUsesRt = 1'($urandom);
      x.idJump = ($urandom_range(0, 3) == 0);
      x.exRs = 5'($urandom_range(0, 3)); x.exRt = 5'($urandom_range(0, 3));
      x.exMemRead = 1'($urandom);
      x.exMulDiv = ($urandom_range(0, 9) == 0);
      x.exWa = 5'($urandom_range(0, 3));
      x.exBranch = ($urandom_range(0, 5) == 0);
      x.exmW = 1'($urandom); x.exmA = 5'($urandom_range(0, 3));
      x.mwW = 1'($urandom); x.mwA = 5'($urandom_range(0, 3));
      step(x, ($urandom_range(0, 49) == 0), "rand", h, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 32, number of EX stall cycles for a mul/div op; legal range 2..255.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_Rs, id_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_UsesRs, id_UsesRt  in  1 each  ID instruction reads Rs/Rt.
REQ-006 SHALL have port id_Jump  in  1  jump resolved in ID.
REQ-007 SHALL have ports ex_Rs, ex_Rt  in  5 each  source registers of the instruction in EX.
REQ-008 SHALL have ports ex_MemRead, ex_MulDiv  in  1 each  EX instruction is a load / a mul-div op.
REQ-009 SHALL have port ex_RegWriteAddr  in  5  destination of the EX instruction.
REQ-010 SHALL have port ex_activeBranch  in  1  branch taken in EX this cycle.
REQ-011 SHALL have ports ex_mem_RegWrite, mem_wb_RegWrite  in  1 each  write enables of later stages.
REQ-012 SHALL have ports ex_mem_RegWriteAddr, mem_wb_RegWriteAddr  in  5 each  destinations of later stages.
REQ-013 SHALL have port pc_hold  out  1  PC keeps its value.
REQ-014 SHALL have ports if_id_regOption, id_ex_regOption, ex_mem_regOption  out  2 each  00 update, 01 bubble, 10 hold.
REQ-015 SHALL have ports forwardA, forwardB  out  2 each  00 register file, 01 MEM/WB data, 10 EX/MEM ALU result.
REQ-016 SHALL have port muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
REQ-017 SHALL have ports stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-018 SHALL drive forwardA = 10 when ex_mem_RegWrite and ex_mem_RegWriteAddr != 0 and == ex_Rs; else 01 when the same holds for mem_wb; else 00; forwardB identical using ex_Rt; combinational, EX/MEM priority.
REQ-019 SHALL implement FSM states RUN, MD_WAIT, MD_DONE and an 8-bit down-counter cnt.
REQ-020 SHALL define load_use = ex_MemRead and ex_RegWriteAddr != 0 and ((id_UsesRs and id_Rs == ex_RegWriteAddr) or (id_UsesRt and id_Rt == ex_RegWriteAddr)).
REQ-021 In RUN, with ex_activeBranch=1: pc_hold=0, if_id=01, id_ex=01, ex_mem=00; highest priority, overrides ex_MulDiv, load_use and id_Jump.
REQ-022 In RUN, else with ex_MulDiv=1: muldiv_start=1, pc_hold=1, if_id=10, id_ex=10, ex_mem=01, cnt<=MULDIV_LAT-1, next state MD_WAIT.
REQ-023 In RUN, else with load_use=1: pc_hold=1, if_id=10, id_ex=01, ex_mem=00; id_Jump ignored this cycle.
REQ-024 In RUN, else with id_Jump=1: pc_hold=0, if_id=01, id_ex=00, ex_mem=00.
REQ-025 In RUN otherwise: pc_hold=0, all regOption=00.
REQ-026 In MD_WAIT: outputs as REQ-022 but muldiv_start=0; cnt decrements each cycle; when cnt==1 next state MD_DONE; all other inputs ignored.
REQ-027 In MD_DONE: pc_hold=0, all regOption=00, muldiv_start=0, next state RUN unconditionally (EX op must not restart).
REQ-028 Total held cycles per mul/div SHALL equal MULDIV_LAT (detect cycle plus MULDIV_LAT-1 MD_WAIT cycles).
REQ-029 stall_cycles SHALL increment in each non-reset cycle with pc_hold=1; flush_count in each cycle with REQ-021 active; both saturate at 0xFFFFFFFF.

Reset
REQ-030 While reset=1: state<=RUN, cnt<=0, counters<=0; combinationally pc_hold=1, all regOption=01, forwardA/B=00, muldiv_start=0.
REQ-031 Reset asserted during MD_WAIT SHALL abort the sequence; first cycle after deassertion is RUN with no muldiv_start unless ex_MulDiv=1.

Verification
REQ-032 Forwarding: ex_Rs=5, ex_mem writes 5, mem_wb writes 5 -> forwardA=10; ex_mem addr=0 -> forwardA=01; mem_wb_RegWrite=0 too -> 00.
REQ-033 Load-use: ex_MemRead=1, ex_RegWriteAddr=8, id_Rt=8, id_UsesRt=1 -> one cycle pc_hold=1, if_id=10, id_ex=01, stall_cycles +1.
REQ-034 Branch+load-use same cycle: ex_activeBranch=1 -> pc_hold=0, if_id=01, id_ex=01, flush_count +1, no stall.
REQ-035 MULDIV_LAT=4, ex_MulDiv=1 held -> muldiv_start high 1 cycle, hold 4 cycles, MD_DONE cycle all 00, back to RUN, stall_cycles +4.
REQ-036 Reset asserted in 2nd MD_WAIT cycle -> regOption all 01 during reset, RUN afterwards, counters 0.
REQ-037 Counter saturation: force stall_cycles to 0xFFFFFFFF, further stall -> stays 0xFFFFFFFF.
